// File: rtl/elastic_align_ctrl_pkg.sv
// Shared definitions for the RX elastic-buffer link supervisor: ALIGNp primitive,
// FSM state codes and the registered input word with its qualifier functions.
package elastic_align_ctrl_pkg;

    localparam logic [31:0] ALIGN_PRIM = 32'h7B4A_4ABC;

    typedef enum logic [2:0] {
        ST_WAIT    = 3'd0,
        ST_SYNC    = 3'd1,
        ST_LOCKED  = 3'd2,
        ST_REALIGN = 3'd3,
        ST_HOLDOFF = 3'd4
    } state_t;

    typedef struct packed {
        logic        en;
        logic        clear_cnt;
        logic        isaligned;
        logic [31:0] data;
        logic [3:0]  charisk;
        logic [3:0]  notintable;
        logic [3:0]  disperror;
        logic        full;
        logic        empty;
    } rx_word_t;

    // A dword carrying any code error can never qualify as ALIGNp.
    function automatic logic is_alignp(input rx_word_t w);
        return (w.data == ALIGN_PRIM) && (w.charisk == 4'h1) &&
               (w.notintable == 4'h0) && (w.disperror == 4'h0);
    endfunction

    function automatic logic is_code_err(input rx_word_t w);
        return (|w.notintable) | (|w.disperror);
    endfunction

endpackage

// File: rtl/elastic_align_ctrl_sat_counter.sv
// Saturating up-counter for link statistics; clear has priority over increment.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst || clr)
            q <= '0;
        else if (inc && (q != '1))
            q <= q + WIDTH'(1);
    end

endmodule

// File: rtl/elastic_align_ctrl.sv
// Link supervisor on the rclk side of the RX elastic buffer: qualifies ALIGNp cadence,
// code errors and slips, declares link_ok, and requests a PHY realign on loss of lock.
module elastic_align_ctrl
    import elastic_align_ctrl_pkg::*;
#(
    parameter int ALIGN_PERIOD_MAX = 256,
    parameter int LOCK_ALIGNS      = 2,
    parameter int ERR_THRESHOLD    = 4,
    parameter int HOLDOFF_CYCLES   = 1024,
    parameter int CNT_WIDTH        = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 clear_cnt,
    input  logic                 isaligned_in,
    input  logic [31:0]          data_in,
    input  logic [3:0]           charisk_in,
    input  logic [3:0]           notintable_in,
    input  logic [3:0]           disperror_in,
    input  logic                 full_in,
    input  logic                 empty_in,
    output logic                 realign_req,
    output logic                 link_ok,
    output logic [2:0]           state,
    output logic [CNT_WIDTH-1:0] err_cnt,
    output logic [CNT_WIDTH-1:0] slip_cnt,
    output logic [CNT_WIDTH-1:0] realign_cnt
);

    localparam int DW_W  = $clog2(ALIGN_PERIOD_MAX + 1);
    localparam int AS_W  = $clog2(LOCK_ALIGNS + 1);
    localparam int ACC_W = $clog2(ERR_THRESHOLD + 1);
    localparam int HO_W  = $clog2(HOLDOFF_CYCLES + 1);

    localparam logic [DW_W-1:0]  DW_LAST = DW_W'(ALIGN_PERIOD_MAX - 1);
    localparam logic [HO_W-1:0]  HO_LAST = HO_W'(HOLDOFF_CYCLES - 1);
    localparam logic [AS_W-1:0]  AS_LOCK = AS_W'(LOCK_ALIGNS);
    localparam logic [ACC_W-1:0] ACC_MAX = ACC_W'(ERR_THRESHOLD);

    rx_word_t         rx_q;
    state_t           state_q, state_nx;
    logic [AS_W-1:0]  seen, seen_nx;
    logic [ACC_W-1:0] acc, acc_nx;
    logic [DW_W-1:0]  dw_cnt;
    logic [HO_W-1:0]  ho_cnt;

    logic alignp, code_err, slip, missing, err_event, hold;

    always_ff @(posedge clk) begin
        if (rst)
            rx_q <= '0;
        else
            rx_q <= '{en: en, clear_cnt: clear_cnt, isaligned: isaligned_in,
                      data: data_in, charisk: charisk_in, notintable: notintable_in,
                      disperror: disperror_in, full: full_in, empty: empty_in};
    end

    assign alignp    = is_alignp(rx_q);
    assign code_err  = is_code_err(rx_q);
    assign slip      = rx_q.full | rx_q.empty;
    // Dword counter parks at its last value, so missing repeats every dword until ALIGNp returns.
    assign missing   = (dw_cnt == DW_LAST) && !alignp;
    assign err_event = code_err | slip | missing;
    assign hold      = (state_q == ST_HOLDOFF);

    always_comb begin
        state_nx = state_q;
        seen_nx  = seen;
        acc_nx   = '0;
        case (state_q)
            ST_WAIT: begin
                seen_nx = '0;
                if (rx_q.isaligned)
                    state_nx = ST_SYNC;
            end
            ST_SYNC: begin
                if (err_event || !rx_q.isaligned) begin
                    state_nx = ST_REALIGN;
                end else if (alignp) begin
                    seen_nx = seen + AS_W'(1);
                    if (seen_nx == AS_LOCK)
                        state_nx = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                // Error and ALIGNp in the same dword cancel out.
                acc_nx = acc;
                if (err_event && !alignp)
                    acc_nx = acc + ACC_W'(1);
                else if (alignp && !err_event && (acc != '0))
                    acc_nx = acc - ACC_W'(1);
                if ((acc_nx == ACC_MAX) || !rx_q.isaligned)
                    state_nx = ST_REALIGN;
            end
            ST_REALIGN: state_nx = ST_HOLDOFF;
            ST_HOLDOFF: begin
                if (ho_cnt == HO_LAST)
                    state_nx = ST_WAIT;
            end
            default: state_nx = ST_WAIT;
        endcase
        if (!rx_q.en)
            state_nx = ST_WAIT;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_WAIT;
            seen        <= '0;
            acc         <= '0;
            dw_cnt      <= '0;
            ho_cnt      <= '0;
            link_ok     <= 1'b0;
            realign_req <= 1'b0;
        end else begin
            state_q     <= state_nx;
            seen        <= seen_nx;
            acc         <= acc_nx;
            link_ok     <= (state_nx == ST_LOCKED);
            realign_req <= (state_nx == ST_REALIGN);
            if (alignp || (state_nx != state_q))
                dw_cnt <= '0;
            else if (dw_cnt != DW_LAST)
                dw_cnt <= dw_cnt + DW_W'(1);
            if (!hold)
                ho_cnt <= '0;
            else
                ho_cnt <= ho_cnt + HO_W'(1);
        end
    end

    assign state = state_q;

    sat_counter #(.WIDTH(CNT_WIDTH)) u_err_cnt (
        .clk(clk), .rst(rst), .inc(code_err && !hold), .clr(rx_q.clear_cnt), .q(err_cnt)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_slip_cnt (
        .clk(clk), .rst(rst), .inc(slip && !hold), .clr(rx_q.clear_cnt), .q(slip_cnt)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_realign_cnt (
        .clk(clk), .rst(rst), .inc(state_q == ST_REALIGN), .clr(rx_q.clear_cnt), .q(realign_cnt)
    );

endmodule

// File: tb/tb_elastic_align_ctrl.sv
// Directed bench for elastic_align_ctrl: status expectations and realign pulses are queued
// by the stimulus thread and compared by an independent negedge monitor.
module tb_elastic_align_ctrl;
    import elastic_align_ctrl_pkg::*;

    localparam int CW = 5;

    logic          clk = 1'b0;
    logic          rst, en, clear_cnt, isaligned_in, full_in, empty_in;
    logic [31:0]   data_in;
    logic [3:0]    charisk_in, notintable_in, disperror_in;
    logic          realign_req, link_ok;
    logic [2:0]    state;
    logic [CW-1:0] err_cnt, slip_cnt, realign_cnt;

    elastic_align_ctrl #(.CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .en(en), .clear_cnt(clear_cnt), .isaligned_in(isaligned_in),
        .data_in(data_in), .charisk_in(charisk_in), .notintable_in(notintable_in),
        .disperror_in(disperror_in), .full_in(full_in), .empty_in(empty_in),
        .realign_req(realign_req), .link_ok(link_ok), .state(state),
        .err_cnt(err_cnt), .slip_cnt(slip_cnt), .realign_cnt(realign_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        string         nm;
        logic [2:0]    st;
        logic          rr;
        logic          lk;
        bit            cc;
        logic [CW-1:0] err, slp, rc;
    } exp_t;

    typedef struct {
        string         nm;
        logic [CW-1:0] rc;
    } pexp_t;

    exp_t  exp_q[$];
    pexp_t pulse_q[$];
    int    ncmp = 0, nfail = 0;
    logic  sample = 1'b0, done = 1'b0, fin = 1'b0, prev_rr = 1'b0;

    // Monitor: the only process that compares and counts.
    always @(negedge clk) begin
        exp_t  e;
        pexp_t p;
        if (sample) begin
            ncmp++;
            if (exp_q.size() == 0) begin
                nfail++;
                $display("FAIL sb_underflow: status sampled with no expectation queued");
            end else begin
                e = exp_q.pop_front();
                if (state !== e.st || realign_req !== e.rr || link_ok !== e.lk ||
                    (e.cc && (err_cnt !== e.err || slip_cnt !== e.slp || realign_cnt !== e.rc))) begin
                    nfail++;
                    $display("FAIL %s: got st=%0d rr=%0b lk=%0b err=%0d slip=%0d rc=%0d, want st=%0d rr=%0b lk=%0b err=%0d slip=%0d rc=%0d (cnt %0s)",
                             e.nm, state, realign_req, link_ok, err_cnt, slip_cnt, realign_cnt,
                             e.st, e.rr, e.lk, e.err, e.slp, e.rc, e.cc ? "checked" : "ignored");
                end
            end
        end
        if (prev_rr) begin
            ncmp++;
            if (realign_req !== 1'b0) begin
                nfail++;
                $display("FAIL pulse_width: realign_req=%0b second cycle, want 0", realign_req);
            end
        end
        if (realign_req === 1'b1 && !prev_rr) begin
            ncmp++;
            if (pulse_q.size() == 0) begin
                nfail++;
                $display("FAIL unexpected_pulse: realign_req=1 in state %0d, want no pulse", state);
            end else begin
                p = pulse_q.pop_front();
                if (realign_cnt !== p.rc || state !== 3'(ST_REALIGN)) begin
                    nfail++;
                    $display("FAIL %s: pulse with rc=%0d st=%0d, want rc=%0d st=%0d",
                             p.nm, realign_cnt, state, p.rc, ST_REALIGN);
                end
            end
        end
        if (done && !fin) begin
            ncmp++;
            if (exp_q.size() != 0 || pulse_q.size() != 0) begin
                nfail++;
                $display("FAIL leftover: status=%0d pulses=%0d outstanding, want 0/0",
                         exp_q.size(), pulse_q.size());
            end
            fin <= 1'b1;
        end
        prev_rr <= realign_req;
    end

    task automatic check(input string nm, input logic [2:0] st, input logic rr, input logic lk,
                         input bit cc, input int err, input int slp, input int rc);
        exp_t e;
        e.nm = nm; e.st = st; e.rr = rr; e.lk = lk; e.cc = cc;
        e.err = CW'(err); e.slp = CW'(slp); e.rc = CW'(rc);
        exp_q.push_back(e);
        sample = 1'b1;
        @(negedge clk);
        #1 sample = 1'b0;
    endtask

    task automatic expect_pulse(input string nm, input int rc);
        pexp_t p;
        p.nm = nm; p.rc = CW'(rc);
        pulse_q.push_back(p);
    endtask

    task automatic send(input logic [31:0] d, input logic [3:0] k, input logic [3:0] nit,
                        input logic [3:0] de, input logic f, input logic em, input logic clr);
        data_in = d; charisk_in = k; notintable_in = nit; disperror_in = de;
        full_in = f; empty_in = em; clear_cnt = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic send_idle(input int n);
        for (int i = 0; i < n; i++) send(32'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic send_align();
        send(32'h7B4A_4ABC, 4'h1, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic clear_stats();
        send(32'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1);
        send_idle(1);
    endtask

    task automatic lock(input string nm);
        isaligned_in = 1'b1;
        send_idle(3);
        send_align();
        send_align();
        send_idle(1);
        check(nm, ST_LOCKED, 1'b0, 1'b1, 1'b0, 0, 0, 0);
    endtask

    // Bounded: if HOLDOFF never ends, the caller's WAIT check reports it.
    task automatic wait_holdoff();
        isaligned_in = 1'b0;
        for (int i = 0; i < 1200 && state != 3'(ST_WAIT); i++) send_idle(1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; en = 1'b0; isaligned_in = 1'b0;
        send_idle(3);
        check("reset", ST_WAIT, 1'b0, 1'b0, 1'b1, 0, 0, 0);
        rst = 1'b0;

        // 1: acquire lock with ALIGNp pairs, hold it for two 200-dword periods
        en = 1'b1; isaligned_in = 1'b1;
        send_idle(2);
        check("t1_sync", ST_SYNC, 1'b0, 1'b0, 1'b1, 0, 0, 0);
        send_idle(50);
        send_align();
        send_align();
        check("t1_one_align", ST_SYNC, 1'b0, 1'b0, 1'b1, 0, 0, 0);
        send_idle(1);
        check("t1_locked", ST_LOCKED, 1'b0, 1'b1, 1'b1, 0, 0, 0);
        for (int r = 0; r < 2; r++) begin
            send_idle(198);
            send_align();
            send_align();
        end
        check("t1_hold_lock", ST_LOCKED, 1'b0, 1'b1, 1'b1, 0, 0, 0);

        // 2: missing ALIGNp -> 4 missing events at dwords 256..259 -> REALIGN, 1024 HOLDOFF
        expect_pulse("t2_pulse", 0);
        send_idle(259);
        check("t2_pre_realign", ST_LOCKED, 1'b0, 1'b1, 1'b1, 0, 0, 0);
        send_idle(1);
        check("t2_realign", ST_REALIGN, 1'b1, 1'b0, 1'b1, 0, 0, 0);
        send_idle(1);
        check("t2_holdoff", ST_HOLDOFF, 1'b0, 1'b0, 1'b1, 0, 0, 1);
        send_idle(1023);
        check("t2_holdoff_end", ST_HOLDOFF, 1'b0, 1'b0, 1'b1, 0, 0, 1);
        send_idle(1);
        check("t2_wait", ST_WAIT, 1'b0, 1'b0, 1'b1, 0, 0, 1);

        // 3: three disparity errors, ALIGNp (acc 2), then errors until acc reaches 4
        lock("t3_lock");
        for (int i = 0; i < 3; i++) send(32'h0, 4'h0, 4'h0, 4'h1, 1'b0, 1'b0, 1'b0);
        send_align();
        send_idle(1);
        check("t3_acc2", ST_LOCKED, 1'b0, 1'b1, 1'b1, 3, 0, 1);
        send(32'h0, 4'h0, 4'h0, 4'h4, 1'b0, 1'b0, 1'b0);
        send_idle(1);
        check("t3_acc3", ST_LOCKED, 1'b0, 1'b1, 1'b1, 4, 0, 1);
        expect_pulse("t3_pulse", 1);
        send(32'h0, 4'h0, 4'h0, 4'h2, 1'b0, 1'b0, 1'b0);
        send_idle(1);
        check("t3_realign", ST_REALIGN, 1'b1, 1'b0, 1'b1, 5, 0, 1);
        wait_holdoff();
        check("t3_wait", ST_WAIT, 1'b0, 1'b0, 1'b1, 5, 0, 2);

        // 4: four full-slip cycles in LOCKED, then a combined full+empty in WAIT
        clear_stats();
        lock("t4_lock");
        expect_pulse("t4_pulse", 0);
        for (int i = 0; i < 4; i++) send(32'h0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0);
        send_idle(1);
        check("t4_realign", ST_REALIGN, 1'b1, 1'b0, 1'b1, 0, 4, 0);
        wait_holdoff();
        check("t4_wait", ST_WAIT, 1'b0, 1'b0, 1'b1, 0, 4, 1);
        send(32'h0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b1, 1'b0);
        send_idle(1);
        check("t4_full_empty", ST_WAIT, 1'b0, 1'b0, 1'b1, 0, 5, 1);

        // 5: isaligned drop -> pulse 2 clk later; rst during HOLDOFF
        clear_stats();
        lock("t5_lock");
        expect_pulse("t5_pulse", 0);
        isaligned_in = 1'b0;
        send_idle(2);
        check("t5_realign", ST_REALIGN, 1'b1, 1'b0, 1'b1, 0, 0, 0);
        send_idle(1);
        check("t5_holdoff", ST_HOLDOFF, 1'b0, 1'b0, 1'b1, 0, 0, 1);
        send_idle(10);
        rst = 1'b1;
        send_idle(1);
        check("t5_rst", ST_WAIT, 1'b0, 1'b0, 1'b1, 0, 0, 0);
        rst = 1'b0;
        send_idle(3);
        check("t5_after_rst", ST_WAIT, 1'b0, 1'b0, 1'b1, 0, 0, 0);

        // 6: saturate err_cnt (5 bits) from WAIT, then clear together with an error
        for (int i = 0; i < 35; i++) send(32'h0, 4'h0, 4'h2, 4'h0, 1'b0, 1'b0, 1'b0);
        send_idle(1);
        check("t6_sat", ST_WAIT, 1'b0, 1'b0, 1'b1, 31, 0, 0);
        send(32'h0, 4'h0, 4'h0, 4'h8, 1'b0, 1'b0, 1'b0);
        send_idle(1);
        check("t6_sat_hold", ST_WAIT, 1'b0, 1'b0, 1'b1, 31, 0, 0);
        send(32'h0, 4'h0, 4'h0, 4'h8, 1'b0, 1'b0, 1'b1);
        send_idle(1);
        check("t6_clr_wins", ST_WAIT, 1'b0, 1'b0, 1'b1, 0, 0, 0);
        send(32'h0, 4'h0, 4'h1, 4'h0, 1'b0, 1'b0, 1'b0);
        send_idle(1);
        check("t6_recount", ST_WAIT, 1'b0, 1'b0, 1'b1, 1, 0, 0);

        // 7: en=0 while LOCKED -> WAIT without a realign pulse
        lock("t7_lock");
        en = 1'b0;
        send_idle(2);
        check("t7_en_off", ST_WAIT, 1'b0, 1'b0, 1'b1, 1, 0, 0);
        send_idle(2);

        done = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
